id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage MIPS core. It sits directly downstream of the instruction decoder. It registers the decoder's control bundle together with register-file read data, the sign-extended immediate, the register indices and PC+4 for the EX stage. It also detects load-use hazards: it stalls fetch/decode and inserts a bubble, and it squashes the stage on a taken-branch flush from MEM.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/id_ex_stage_hazard_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared control-bundle type, ALU-op codes and helpers for the core
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       memwrite;
    logic       memread;
    logic       mem2reg;
    logic [2:0] aluop;
  } ctrl_t;

  localparam logic [2:0] ALUOP_RTYPE    = 3'b010;
  localparam logic [2:0] ALUOP_ADDI_MEM = 3'b100;
  localparam logic [2:0] ALUOP_BEQ      = 3'b101;
  localparam logic [2:0] ALUOP_SLTI     = 3'b111;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // R-type, beq and sw are the only formats that actually read rt.
  function automatic logic rt_used(input logic regdst, input logic branch,
                                   input logic memwrite);
    return regdst | branch | memwrite;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_unit.sv
// ============================================================================
// hazard_unit : combinational load-use comparator between EX load and ID reads
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_unit
  import cpu_pkg::*;
(
  input  logic       ex_memread,
  input  logic       ex_valid,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       regdst,
  input  logic       branch,
  input  logic       memwrite,
  output logic       hazard
);

  logic w_rt_used;

  assign w_rt_used = rt_used(regdst, branch, memwrite);

  // Register 0 is hard-wired, so a load into it can never be a real producer.
  assign hazard = ex_memread & ex_valid & (ex_rt != 5'd0) &
                  ((ex_rt == rs) | ((ex_rt == rt) & w_rt_used));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use stall and branch flush
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             regwrite_i,
  input  logic             alusrc_i,
  input  logic             regdst_i,
  input  logic             branch_i,
  input  logic             memwrite_i,
  input  logic             memread_i,
  input  logic             mem2reg_i,
  input  logic [2:0]       aluop_i,
  input  logic [DW-1:0]    pc4_i,
  input  logic [DW-1:0]    rs_data_i,
  input  logic [DW-1:0]    rt_data_i,
  input  logic [DW-1:0]    imm_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic             ex_regwrite_o,
  output logic             ex_alusrc_o,
  output logic             ex_regdst_o,
  output logic             ex_branch_o,
  output logic             ex_memwrite_o,
  output logic             ex_memread_o,
  output logic             ex_mem2reg_o,
  output logic [2:0]       ex_aluop_o,
  output logic [DW-1:0]    ex_pc4_o,
  output logic [DW-1:0]    ex_rs_data_o,
  output logic [DW-1:0]    ex_rt_data_o,
  output logic [DW-1:0]    ex_imm_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_valid_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t            w_id_ctrl;
  ctrl_t            r_ex_ctrl;
  logic             r_ex_valid;
  logic             w_hazard;
  logic             w_bubble;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_id_ctrl = {regwrite_i, alusrc_i, regdst_i, branch_i, memwrite_i,
                      memread_i, mem2reg_i, aluop_i};

  hazard_unit u_hazard (
    .ex_memread (r_ex_ctrl.memread),
    .ex_valid   (r_ex_valid),
    .ex_rt      (ex_rt_o),
    .rs         (rs_i),
    .rt         (rt_i),
    .regdst     (regdst_i),
    .branch     (branch_i),
    .memwrite   (memwrite_i),
    .hazard     (w_hazard)
  );

  // A flush already empties the stage, so it masks the stall request.
  assign stall_o  = w_hazard & ~flush_i;
  assign w_bubble = flush_i | stall_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_valid   <= 1'b0;
      ex_pc4_o     <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_ex_ctrl    <= w_bubble ? CTRL_BUBBLE : w_id_ctrl;
      r_ex_valid   <= ~w_bubble;
      ex_pc4_o     <= pc4_i;
      ex_rs_data_o <= rs_data_i;
      ex_rt_data_o <= rt_data_i;
      ex_imm_o     <= imm_i;
      ex_rs_o      <= rs_i;
      ex_rt_o      <= rt_i;
      ex_rd_o      <= rd_i;
      if (flush_i) begin
        if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else if (stall_o) begin
        if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign ex_regwrite_o = r_ex_ctrl.regwrite;
  assign ex_alusrc_o   = r_ex_ctrl.alusrc;
  assign ex_regdst_o   = r_ex_ctrl.regdst;
  assign ex_branch_o   = r_ex_ctrl.branch;
  assign ex_memwrite_o = r_ex_ctrl.memwrite;
  assign ex_memread_o  = r_ex_ctrl.memread;
  assign ex_mem2reg_o  = r_ex_ctrl.mem2reg;
  assign ex_aluop_o    = r_ex_ctrl.aluop;
  assign ex_valid_o    = r_ex_valid;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed bench for id_ex_stage with a cycle-level reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // {regwrite, alusrc, regdst, branch, memwrite, memread, mem2reg, aluop}
  localparam logic [9:0] C_ADD  = 10'b1010000_010;
  localparam logic [9:0] C_LW   = 10'b1100011_100;
  localparam logic [9:0] C_ADDI = 10'b1100000_100;
  localparam logic [9:0] C_BEQ  = 10'b0001000_101;
  localparam logic [9:0] C_SW   = 10'b0100100_100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [9:0]    cin = '0;
  logic [DW-1:0] pc4 = '0, rsd = '0, rtd = '0, imm = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0;

  logic          ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memwrite;
  logic          ex_memread, ex_mem2reg, ex_valid, stall;
  logic [2:0]    ex_aluop;
  logic [DW-1:0] ex_pc4, ex_rsd, ex_rtd, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .regwrite_i(cin[9]), .alusrc_i(cin[8]), .regdst_i(cin[7]), .branch_i(cin[6]),
    .memwrite_i(cin[5]), .memread_i(cin[4]), .mem2reg_i(cin[3]), .aluop_i(cin[2:0]),
    .pc4_i(pc4), .rs_data_i(rsd), .rt_data_i(rtd), .imm_i(imm),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .flush_i(flush),
    .ex_regwrite_o(ex_regwrite), .ex_alusrc_o(ex_alusrc), .ex_regdst_o(ex_regdst),
    .ex_branch_o(ex_branch), .ex_memwrite_o(ex_memwrite), .ex_memread_o(ex_memread),
    .ex_mem2reg_o(ex_mem2reg), .ex_aluop_o(ex_aluop),
    .ex_pc4_o(ex_pc4), .ex_rs_data_o(ex_rsd), .ex_rt_data_o(ex_rtd), .ex_imm_o(ex_imm),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
    .ex_valid_o(ex_valid), .stall_o(stall),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Reference state: what the EX slot must hold according to the stage rules.
  logic [9:0]    m_ctrl = '0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_pc4 = '0, m_rsd = '0, m_rtd = '0, m_imm = '0;
  logic [4:0]    m_rs = '0, m_rt = '0, m_rd = '0;
  int            m_scnt = 0, m_fcnt = 0;
  logic          m_stall_now;

  function automatic logic exp_stall();
    logic rt_read;
    rt_read = cin[7] | cin[6] | cin[5];
    return m_ctrl[4] && m_valid && (m_rt != 0) &&
           ((m_rt == rs) || ((m_rt == rt) && rt_read)) && !flush;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ctrl = '0; m_valid = 1'b0; m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_scnt = 0; m_fcnt = 0;
    end else begin
      m_stall_now = exp_stall();
      if (flush) begin
        m_ctrl = '0; m_valid = 1'b0;
        if (m_fcnt < CMAX) m_fcnt = m_fcnt + 1;
      end else if (m_stall_now) begin
        m_ctrl = '0; m_valid = 1'b0;
        if (m_scnt < CMAX) m_scnt = m_scnt + 1;
      end else begin
        m_ctrl = cin; m_valid = 1'b1;
      end
      m_pc4 = pc4; m_rsd = rsd; m_rtd = rtd; m_imm = imm;
      m_rs = rs; m_rt = rt; m_rd = rd;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ctrl", {ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memwrite,
                 ex_memread, ex_mem2reg, ex_aluop}, m_ctrl);
    chk("valid", ex_valid, m_valid);
    chk("data", {ex_rsd, ex_rtd}, {m_rsd, m_rtd});
    chk("pc4_imm", {ex_pc4, ex_imm}, {m_pc4, m_imm});
    chk("idx", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
    chk("stall", stall, exp_stall());
    chk("cnts", {stall_cnt, flush_cnt}, {m_scnt[CNT_W-1:0], m_fcnt[CNT_W-1:0]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] c, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [DW-1:0] sd,
                       input logic [DW-1:0] td, input logic [DW-1:0] im);
    cin = c; rs = s; rt = t; rd = d; rsd = sd; rtd = td; imm = im;
    pc4 = pc4 + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(10'd0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_regwrite", ex_regwrite, 0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
    rst = 1'b1;

    // Pass-through of an R-type add
    drive(C_ADD, 8, 9, 10, 32'h5, 32'h7, 0);
    #1 chk("pt_stall", stall, 0);
    tick();
    chk("pt_ctrl", {ex_regwrite, ex_regdst, ex_aluop}, {1'b1, 1'b1, 3'b010});
    chk("pt_idx", {ex_rs, ex_rt, ex_rd}, {5'd8, 5'd9, 5'd10});
    chk("pt_data", {ex_rsd, ex_rtd}, {32'h5, 32'h7});
    chk("pt_valid", ex_valid, 1);

    // Load-use on rt of an R-type
    drive(C_LW, 4, 9, 0, 32'h100, 0, 32'h8);
    tick();
    chk("lw_memread", ex_memread, 1);
    drive(C_ADD, 8, 9, 11, 32'h1, 32'h2, 0);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", {ex_valid, ex_regwrite, ex_regdst}, 0);
    chk("lu_scnt", stall_cnt, 1);
    #1 chk("lu_stall_drop", stall, 0);
    tick();
    chk("lu_capture", {ex_valid, ex_regdst, ex_rd}, {1'b1, 1'b1, 5'd11});

    // lw rt=9 then addi rt=9: rt not read
    drive(C_LW, 4, 9, 0, 0, 0, 0); tick();
    drive(C_ADDI, 4, 9, 0, 0, 0, 32'h3);
    #1 chk("addi_nostall", stall, 0);
    tick();

    // lw into r0 never stalls
    drive(C_LW, 4, 0, 0, 0, 0, 0); tick();
    drive(C_ADD, 0, 0, 3, 0, 0, 0);
    #1 chk("r0_nostall", stall, 0);
    tick();

    // Flush wins over a simultaneous load-use
    drive(C_LW, 4, 9, 0, 0, 0, 0); tick();
    flush = 1'b1;
    drive(C_ADD, 9, 1, 2, 0, 0, 0);
    #1 chk("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("fl_bubble", {ex_valid, ex_regwrite}, 0);
    chk("fl_cnts", {stall_cnt, flush_cnt}, {4'd1, 4'd1});

    // beq and sw read rt
    drive(C_LW, 4, 7, 0, 0, 0, 0); tick();
    drive(C_BEQ, 1, 7, 0, 0, 0, 32'h10);
    #1 chk("beq_stall", stall, 1);
    tick();
    drive(C_LW, 4, 6, 0, 0, 0, 0); tick();
    drive(C_SW, 2, 6, 0, 0, 0, 32'h4);
    #1 chk("sw_stall", stall, 1);
    tick();
    chk("scnt3", stall_cnt, 3);

    // Saturation: 17 more stalls
    for (int i = 0; i < 17; i++) begin
      drive(C_LW, 4, 5, 0, i, 0, 0); tick();
      drive(C_ADD, 5, 1, 2, 0, 0, 0); tick();
    end
    chk("sat_scnt", stall_cnt, 4'hF);
    chk("sat_fcnt", flush_cnt, 1);

    // Asynchronous reset between edges
    drive(C_ADD, 3, 4, 5, 32'hA, 32'hB, 0); tick();
    chk("ar_pre", ex_regwrite, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_ctrl", {ex_regwrite, ex_regdst, ex_aluop, ex_valid}, 0);
    chk("ar_data", {ex_rsd, ex_rd}, 0);
    chk("ar_cnts", {stall_cnt, flush_cnt}, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_capture", {ex_valid, ex_regwrite, ex_rsd}, {1'b1, 1'b1, 32'hA});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
